// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one wishbone SPI master between three host command channels.
// Each channel holds one outstanding command; responses and sticky errors are kept per channel.
module spi_cmd_arbiter #(
   parameter int N_REQ   = 3,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic [N_REQ*DATA_W-1:0] req_cmd,
   input  logic [N_REQ-1:0]        req_trig,
   output logic [N_REQ-1:0]        req_pend,
   output logic [N_REQ-1:0]        req_done,
   output logic [N_REQ*DATA_W-1:0] req_rdata,
   output logic [N_REQ-1:0]        req_err,
   input  logic                    err_clr,
   output logic [DATA_W-1:0]       m_cmd,
   output logic                    m_valid,
   input  logic                    m_ready,
   input  logic                    m_done,
   input  logic [DATA_W-1:0]       m_rdata,
   output logic [1:0]              grant
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t            state;
   logic [1:0]        last_grant;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] hold [N_REQ];
   logic [N_REQ-1:0]  resp_clr;
   logic [N_REQ-1:0]  cap;
   logic [N_REQ-1:0]  drop;
   logic [N_REQ-1:0]  tmo_set;
   logic              tmo_hit;

   // Closest pending channel after last_grant wins; the k=1 candidate is evaluated last.
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] pend, input logic [1:0] last);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = 2'((int'(last) + k) % N_REQ);
         if (pend[idx]) pick = idx;
      end
      return pick;
   endfunction

   always_comb begin
      resp_clr = '0;
      tmo_set  = '0;
      tmo_hit  = (state == WAIT) && !m_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
      if (state == RESP) resp_clr[grant] = 1'b1;
      if (tmo_hit) tmo_set[grant] = 1'b1;
      // A completion clearing pend in the same cycle makes room for a new capture.
      cap  = req_trig & (~req_pend | resp_clr);
      drop = req_trig & req_pend & ~resp_clr;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++)
         if (cap[i]) hold[i] <= req_cmd[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= IDLE;
         m_valid    <= 1'b0;
         m_cmd      <= '0;
         grant      <= 2'd0;
         last_grant <= 2'd2;
         req_pend   <= '0;
         req_done   <= '0;
         req_rdata  <= '0;
         req_err    <= '0;
         wait_cnt   <= '0;
      end else begin
         req_done <= '0;
         req_pend <= (req_pend & ~resp_clr) | cap;
         req_err  <= (err_clr ? '0 : req_err) | drop | tmo_set;
         case (state)
            IDLE: begin
               if (|req_pend) begin
                  grant <= rr_pick(req_pend, last_grant);
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!m_valid) begin
                  m_valid <= 1'b1;
                  m_cmd   <= hold[grant];
               end else if (m_ready) begin
                  m_valid  <= 1'b0;
                  wait_cnt <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (m_done) begin
                  req_rdata[int'(grant)*DATA_W +: DATA_W] <= m_rdata;
                  state <= RESP;
               end else if (tmo_hit) begin
                  req_rdata[int'(grant)*DATA_W +: DATA_W] <= '0;
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               req_done[grant] <= 1'b1;
               last_grant      <= grant;
               wait_cnt        <= '0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Randomized bench for spi_cmd_arbiter: queue-based reference of service order and responses,
// with a behavioural SPI master and a decoupled completion monitor.
`timescale 1ns/1ps
module tb_spi_cmd_arbiter;
   logic        clk;
   logic        rstb;
   logic [95:0] req_cmd;
   logic [2:0]  req_trig;
   logic [2:0]  req_pend;
   logic [2:0]  req_done;
   logic [95:0] req_rdata;
   logic [2:0]  req_err;
   logic        err_clr;
   logic [31:0] m_cmd;
   logic        m_valid;
   logic        m_ready;
   logic        m_done;
   logic [31:0] m_rdata;
   logic [1:0]  grant;

   spi_cmd_arbiter #(.N_REQ(3), .DATA_W(32), .TIMEOUT(1023)) dut (
      .clk(clk), .rstb(rstb), .req_cmd(req_cmd), .req_trig(req_trig), .req_pend(req_pend),
      .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err), .err_clr(err_clr),
      .m_cmd(m_cmd), .m_valid(m_valid), .m_ready(m_ready), .m_done(m_done),
      .m_rdata(m_rdata), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int ch; logic [31:0] cmd; } iss_t;
   typedef struct { int ch; logic [31:0] rdata; logic err; logic pend; } done_t;

   iss_t  iss_q[$];
   done_t done_q[$];
   int    checks = 0;
   int    errors = 0;
   int    model_last = 2;
   int    done_in = 0;
   int    force_delay = 0;
   logic [31:0] cur_rdata = '0;
   logic  chk_low = 1'b0;
   logic  hs_seen = 1'b0;
   logic  ready_hold = 1'b0;
   logic  no_spur = 1'b0;
   logic  clr_with_drop = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Master response word derived from the command; bit pattern 8'hEE in the low byte means "never answer".
   function automatic logic [31:0] rsp_of(input logic [31:0] c);
      if (c == 32'h8000_1234) return 32'h0000_ABCD;
      return {c[15:0], c[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic step();
      @(negedge clk);
      req_trig = '0;
      err_clr  = 1'b0;
      m_done   = 1'b0;
      if (chk_low) begin
         chk("m_valid_after_accept", 128'(m_valid), 128'(0));
         chk_low = 1'b0;
      end
      if (done_in == 1) begin
         m_done  = 1'b1;
         m_rdata = cur_rdata;
      end
      if (done_in > 0) done_in--;
      m_ready = !ready_hold && ($urandom_range(0, 3) != 0);
      if (m_valid && !m_ready && !m_done && !no_spur && $urandom_range(0, 7) == 0) begin
         m_done  = 1'b1;
         m_rdata = $urandom;
      end
      if (m_valid && m_ready) begin
         iss_t e;
         hs_seen = 1'b1;
         chk_low = 1'b1;
         if (iss_q.size() == 0) begin
            chk("unexpected_issue", 128'(m_cmd), 128'(0));
         end else begin
            e = iss_q.pop_front();
            chk("m_cmd", 128'(m_cmd), 128'(e.cmd));
            chk("grant", 128'(grant), 128'(e.ch));
         end
         if (m_cmd[7:0] != 8'hEE) begin
            if (force_delay > 0) done_in = force_delay;
            else if (m_cmd == 32'h8000_1234) done_in = 20;
            else done_in = $urandom_range(1, 25);
            cur_rdata = rsp_of(m_cmd);
         end
      end
   endtask

   always @(negedge clk) begin : mon
      done_t      e;
      logic [2:0] oh;
      if (rstb && req_done != '0) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 128'(req_done), 128'(0));
         end else begin
            e  = done_q.pop_front();
            oh = 3'b001 << e.ch;
            chk("req_done", 128'(req_done), 128'(oh));
            chk("req_rdata", 128'(req_rdata[e.ch*32 +: 32]), 128'(e.rdata));
            chk("req_pend", 128'(req_pend[e.ch]), 128'(e.pend));
            chk("req_err", 128'(req_err[e.ch]), 128'(e.err));
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_m_valid"}, 128'(m_valid), 128'(0));
      chk({tag, "_m_cmd"}, 128'(m_cmd), 128'(0));
      chk({tag, "_grant"}, 128'(grant), 128'(0));
      chk({tag, "_pend"}, 128'(req_pend), 128'(0));
      chk({tag, "_done"}, 128'(req_done), 128'(0));
      chk({tag, "_rdata"}, 128'(req_rdata), 128'(0));
      chk({tag, "_err"}, 128'(req_err), 128'(0));
   endtask

   task automatic clear_err();
      step();
      err_clr = 1'b1;
      step();
      chk("err_clr", 128'(req_err), 128'(0));
   endtask

   // Service order for a simultaneous burst is a cyclic walk from the channel after the last winner.
   task automatic launch(input logic [2:0] mask, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input int drop_ch);
      logic [31:0] c [3];
      int          base;
      int          ch;
      logic        t;
      c[0] = c0; c[1] = c1; c[2] = c2;
      base = model_last;
      for (int k = 1; k <= 3; k++) begin
         ch = (base + k) % 3;
         if (mask[ch]) begin
            t = (c[ch][7:0] == 8'hEE);
            iss_q.push_back('{ch, c[ch]});
            done_q.push_back('{ch, t ? 32'h0 : rsp_of(c[ch]), t || (drop_ch == ch), 1'b0});
            model_last = ch;
         end
      end
      req_cmd  = {c2, c1, c0};
      req_trig = mask;
      if (drop_ch >= 0) begin
         step();
         req_trig[drop_ch]         = 1'b1;
         req_cmd[drop_ch*32 +: 32] = c[drop_ch] ^ 32'h00FF_FF00;
         if (clr_with_drop) err_clr = 1'b1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((iss_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
         step();
         n++;
      end
      chk("drain_outstanding", 128'(iss_q.size() + done_q.size()), 128'(0));
      iss_q.delete();
      done_q.delete();
      step();
      step();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          n;
      int          d;
      logic        stable;
      logic [2:0]  mask;
      logic [31:0] c [3];
      rstb = 1'b0; req_cmd = '0; req_trig = '0; err_clr = 1'b0;
      m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
      repeat (3) step();
      check_reset_vals("reset");
      rstb = 1'b1;

      // single transaction with first-issue latency
      clear_err();
      launch(3'b010, 32'h0, 32'h8000_1234, 32'h0, -1);
      n = 0;
      do begin step(); n++; end while (!m_valid && n < 10);
      chk("issue_latency", 128'(n), 128'(3));
      drain();
      chk("single_pend", 128'(req_pend), 128'(0));

      // round-robin bursts
      clear_err(); launch(3'b111, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, -1); drain();
      clear_err(); launch(3'b111, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006, -1); drain();
      clear_err(); launch(3'b001, 32'h7777_0007, 32'h0, 32'h0, -1); drain();
      clear_err(); launch(3'b101, 32'h8888_0008, 32'h0, 32'h9999_0009, -1); drain();

      // backpressure
      clear_err();
      ready_hold = 1'b1;
      launch(3'b100, 32'h0, 32'h0, 32'hC0DE_0042, -1);
      n = 0;
      while (!m_valid && n < 10) begin step(); n++; end
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         stable &= m_valid && (m_cmd == 32'hC0DE_0042);
      end
      chk("backpressure_stable", 128'(stable), 128'(1));
      ready_hold = 1'b0;
      drain();

      // timeout, then err_clr
      clear_err();
      launch(3'b001, 32'h0BAD_00EE, 32'h0, 32'h0, -1);
      drain();
      chk("timeout_err_sticky", 128'(req_err[0]), 128'(1));
      clear_err();

      // dropped trigger with a coincident err_clr
      clear_err();
      clr_with_drop = 1'b1;
      launch(3'b100, 32'h0, 32'h0, 32'hD00D_0F0F, 2);
      clr_with_drop = 1'b0;
      step();
      chk("drop_err", 128'(req_err[2]), 128'(1));
      drain();

      // retrigger in the completion cycle
      clear_err();
      no_spur = 1'b1;
      launch(3'b010, 32'h0, 32'h1357_2468, 32'h0, -1);
      n = 0;
      while (!m_done && n < 200) begin step(); n++; end
      chk("retrig_m_done_seen", 128'(m_done), 128'(1));
      step();
      req_trig = 3'b010;
      req_cmd[32 +: 32] = 32'h2468_1357;
      if (done_q.size() != 0) done_q[0].pend = 1'b1;
      iss_q.push_back('{1, 32'h2468_1357});
      done_q.push_back('{1, rsp_of(32'h2468_1357), 1'b0, 1'b0});
      drain();
      no_spur = 1'b0;
      chk("retrig_no_err", 128'(req_err), 128'(0));

      // reset while waiting for the master
      clear_err();
      force_delay = 40;
      hs_seen = 1'b0;
      launch(3'b001, 32'h5555_AAAA, 32'h0, 32'h0, -1);
      n = 0;
      while (!hs_seen && n < 100) begin step(); n++; end
      step(); step();
      force_delay = 0;
      #2 rstb = 1'b0;
      #1 check_reset_vals("rst_wait");
      iss_q.delete(); done_q.delete();
      model_last = 2;
      chk_low = 1'b0;
      repeat (3) step();
      rstb = 1'b1;
      repeat (60) step();
      chk("rst_late_done_pend", 128'(req_pend), 128'(0));
      chk("rst_late_done_rdata", 128'(req_rdata), 128'(0));
      clear_err(); launch(3'b111, 32'hA0A0_0101, 32'hB0B0_0202, 32'hC0C0_0303, -1); drain();

      // randomized bursts
      for (int it = 0; it < 30; it++) begin
         clear_err();
         mask = 3'($urandom_range(1, 7));
         for (int j = 0; j < 3; j++) begin
            c[j] = $urandom;
            if (c[j][7:0] == 8'hEE) c[j][7:0] = 8'h11;
            if ($urandom_range(0, 11) == 0) c[j][7:0] = 8'hEE;
         end
         d = -1;
         if ($urandom_range(0, 2) == 0) begin
            d = $urandom_range(0, 2);
            while (!mask[d[1:0]]) d = (d + 1) % 3;
         end
         launch(mask, c[0], c[1], c[2], d);
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of host command channels (fixed 3 in this revision).
REQ-002 SHALL have parameter DATA_W, default 32: command and response word width.
REQ-003 SHALL have parameter TIMEOUT, default 1023: maximum WAIT cycles before a transaction aborts.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on rising edge.
REQ-005 SHALL have port rstb, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_cmd, input, 3*DATA_W: channel i command at [i*32 +: 32], sourced from host wire-ins.
REQ-007 SHALL have port req_trig, input, 3: one-cycle pulse per channel marking req_cmd valid.
REQ-008 SHALL have port req_pend, output, 3: channel command captured and not yet completed.
REQ-009 SHALL have port req_done, output, 3: one-cycle completion pulse per channel.
REQ-010 SHALL have port req_rdata, output, 3*DATA_W: last response per channel, held until that channel's next completion.
REQ-011 SHALL have port req_err, output, 3: sticky per channel; set on timeout or dropped trigger.
REQ-012 SHALL have port err_clr, input, 1: synchronous clear of req_err.
REQ-013 SHALL have port m_cmd, output, DATA_W: command to the shared wishbone SPI master.
REQ-014 SHALL have port m_valid, output, 1: m_cmd valid.
REQ-015 SHALL have port m_ready, input, 1: master accepts the command when m_valid && m_ready.
REQ-016 SHALL have port m_done, input, 1: one-cycle pulse; m_rdata valid.
REQ-017 SHALL have port m_rdata, input, DATA_W: master response word.
REQ-018 SHALL have port grant, output, 2: channel owning the SPI pins (drives the sclk/mosi/ss mux); holds its value while idle.

Function
REQ-019 SHALL capture req_cmd[i] into a per-channel holding register and set req_pend[i] on the cycle after req_trig[i] when req_pend[i]==0.
REQ-020 SHALL ignore req_trig[i] while req_pend[i]==1 (holding register unchanged) and set req_err[i].
REQ-021 SHALL have FSM states IDLE, ISSUE, WAIT, RESP, encoded 2 bits.
REQ-022 In IDLE, if any req_pend is set, SHALL select one channel by round-robin, starting at (last_grant+1) mod 3, load grant, and go to ISSUE the next cycle.
REQ-023 In ISSUE, SHALL drive m_valid=1 and m_cmd=holding[grant] until m_ready, then go to WAIT with m_valid=0 on the next cycle.
REQ-024 In WAIT, SHALL count cycles from 0; on m_done SHALL latch m_rdata into req_rdata[grant] and go to RESP.
REQ-025 In WAIT, if the count reaches TIMEOUT without m_done, SHALL write 0 to req_rdata[grant], set req_err[grant], and go to RESP.
REQ-026 In RESP (one cycle), SHALL pulse req_done[grant], clear req_pend[grant], update last_grant=grant, and return to IDLE.
REQ-027 Latency: trigger on an idle arbiter -> m_valid asserted 3 cycles later (capture, IDLE select, ISSUE).
REQ-028 A req_trig[g] arriving in the same cycle as RESP clears req_pend[g] SHALL be captured (clear has priority, then set), with no err.
REQ-029 m_done outside WAIT SHALL be ignored.
REQ-030 err_clr coincident with a new error SHALL leave the new error set.
REQ-031 grant SHALL not change outside the IDLE->ISSUE transition.

Reset
REQ-032 On rstb low SHALL immediately force: state IDLE, m_valid 0, m_cmd 0, grant 0, last_grant 2 (first winner is channel 0), req_pend 0, req_done 0, req_rdata 0, req_err 0, timeout counter 0.
REQ-033 Reset asserted mid-transaction SHALL abandon it without a req_done pulse; a later m_done SHALL be ignored.
REQ-034 Deassertion SHALL be synchronized by the integrator; the block assumes a clean release.

Verification
REQ-035 Single: trig ch1 with cmd 0x8000_1234, m_ready=1, m_done after 20 cycles with rdata 0x0000_ABCD -> m_cmd=0x8000_1234, grant=1, req_rdata[1]=0x0000_ABCD, one req_done[1] pulse, req_pend=0.
REQ-036 Round-robin: trig all three in the same cycle -> service order 0,1,2; next simultaneous burst after last_grant=2 -> again 0,1,2; with last_grant=0 and ch0,ch2 pending -> order 2,0.
REQ-037 Backpressure: m_ready held low 50 cycles -> m_valid and m_cmd stable throughout; WAIT begins the cycle after m_ready.
REQ-038 Timeout: no m_done -> after 1023 WAIT cycles req_rdata[g]=0, req_err[g]=1, req_done[g] pulses; err_clr clears req_err.
REQ-039 Drop: second trig on ch2 while pending with a different cmd -> original cmd issued, req_err[2]=1.
REQ-040 Reset in WAIT -> all outputs at reset values; a following m_done produces no req_done.
